// File: rtl/uart_pkg.sv
// Shared constants for the UART MMIO peripheral: register offsets, STATUS bit
// positions, FSM state encoding and the divider floor.
package uart_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_RXDATA = 2'd2;
   localparam logic [1:0] REG_DIV    = 2'd3;

   localparam int STAT_TX_BUSY  = 0;
   localparam int STAT_TX_FULL  = 1;
   localparam int STAT_RX_VALID = 2;
   localparam int STAT_TX_OVF   = 3;
   localparam int STAT_RX_OVR   = 4;
   localparam int STAT_RX_FERR  = 5;

   localparam logic [15:0] DIV_MIN = 16'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module uart_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [7:0]               i_data,
   output logic [7:0]               o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == LP_DEPTH);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: register file, TX FIFO + TX FSM, and an optional
// receiver built only when UART_RX_EN is defined.
//
// state   | meaning
// IDLE    | line high, waiting for work (TX: FIFO non-empty, RX: falling edge)
// START   | start bit (RX: wait half a bit, then confirm low)
// DATA    | 8 data bits, LSB first, one bit per DIV cycles
// STOP    | stop bit
module uart_mmio
   import uart_pkg::*;
#(
   parameter int DIV_DEFAULT = 434,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] uart_addr,
   input  logic [31:0] uart_write_data,
   input  logic        uart_wen,
   output logic [31:0] uart_read_data,
   output logic        uart_txd,
   input  logic        uart_rxd
);

   localparam logic [15:0] LP_DIV_RST = 16'(DIV_DEFAULT);

   logic [15:0]             r_div;
   logic                    r_tx_ovf;
   logic                    w_wr_tx, w_wr_stat, w_wr_rx, w_wr_div;
   logic [7:0]              w_fifo_data;
   logic                    w_fifo_full, w_fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
   uart_state_t             r_tx_state, w_tx_next;
   logic [15:0]             r_tx_cnt, r_tx_div;
   logic [2:0]              r_tx_bit;
   logic [7:0]              r_tx_shift;
   logic                    w_tx_pop, w_tx_zero;
   logic                    w_rx_valid, w_rx_ovr, w_rx_ferr;
   logic [7:0]              w_rx_byte;
   logic [5:0]              w_status;
   logic                    w_unused;

   assign w_wr_tx   = uart_wen && (uart_addr[3:2] == REG_TXDATA);
   assign w_wr_stat = uart_wen && (uart_addr[3:2] == REG_STATUS);
   assign w_wr_rx   = uart_wen && (uart_addr[3:2] == REG_RXDATA);
   assign w_wr_div  = uart_wen && (uart_addr[3:2] == REG_DIV);
   assign w_tx_zero = (r_tx_cnt == 16'd0);
   assign w_unused  = ^{uart_rxd, w_wr_rx, uart_write_data[31:16], uart_addr[31:4],
                        uart_addr[1:0], w_fifo_count};

   uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_wr_tx),
      .i_pop   (w_tx_pop),
      .i_data  (uart_write_data[7:0]),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div    <= LP_DIV_RST;
         r_tx_ovf <= 1'b0;
      end else begin
         if (w_wr_div) r_div <= clamp_div(uart_write_data[15:0]);
         if (w_wr_stat && uart_write_data[STAT_TX_OVF]) r_tx_ovf <= 1'b0;
         if (w_wr_tx && w_fifo_full && !w_tx_pop)       r_tx_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tx_state <= S_IDLE;
      else     r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         S_IDLE:  if (!w_fifo_empty) w_tx_next = S_START;
         S_START: if (w_tx_zero) w_tx_next = S_DATA;
         S_DATA:  if (w_tx_zero && r_tx_bit == 3'd7) w_tx_next = S_STOP;
         S_STOP:  if (w_tx_zero) w_tx_next = w_fifo_empty ? S_IDLE : S_START;
         default: w_tx_next = S_IDLE;
      endcase
   end

   // txd is decoded from state so an async reset drives the line high at once
   always_comb begin
      uart_txd = 1'b1;
      w_tx_pop = 1'b0;
      case (r_tx_state)
         S_IDLE:  w_tx_pop = !w_fifo_empty;
         S_START: uart_txd = 1'b0;
         S_DATA:  uart_txd = r_tx_shift[0];
         S_STOP:  w_tx_pop = w_tx_zero && !w_fifo_empty;
         default: uart_txd = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_cnt   <= 16'd0;
         r_tx_div   <= LP_DIV_RST;
         r_tx_bit   <= 3'd0;
         r_tx_shift <= 8'd0;
      end else if (w_tx_pop) begin
         r_tx_shift <= w_fifo_data;
         r_tx_cnt   <= r_div - 16'd1;
         r_tx_div   <= r_div;
      end else begin
         case (r_tx_state)
            S_START: if (w_tx_zero) begin
                        r_tx_cnt <= r_tx_div - 16'd1;
                        r_tx_bit <= 3'd0;
                     end else r_tx_cnt <= r_tx_cnt - 16'd1;
            S_DATA:  if (w_tx_zero) begin
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_cnt   <= r_tx_div - 16'd1;
                     end else r_tx_cnt <= r_tx_cnt - 16'd1;
            S_STOP:  if (!w_tx_zero) r_tx_cnt <= r_tx_cnt - 16'd1;
            default: ;
         endcase
      end
   end

`ifdef UART_RX_EN
   logic          r_rx_s1, r_rx_s2, r_rx_s3;
   uart_state_t   r_rx_state, w_rx_next;
   logic [15:0]   r_rx_cnt, r_rx_div;
   logic [2:0]    r_rx_bit;
   logic [7:0]    r_rx_shift, r_rx_byte;
   logic          r_rx_valid, r_rx_ovr, r_rx_ferr;
   logic          w_rx_fall, w_rx_zero, w_rx_done;

   assign w_rx_fall  = r_rx_s3 & ~r_rx_s2;
   assign w_rx_zero  = (r_rx_cnt == 16'd0);
   assign w_rx_done  = (r_rx_state == S_STOP) && w_rx_zero;
   assign w_rx_valid = r_rx_valid;
   assign w_rx_ovr   = r_rx_ovr;
   assign w_rx_ferr  = r_rx_ferr;
   assign w_rx_byte  = r_rx_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rx_state <= S_IDLE;
      else     r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
         S_START: if (w_rx_zero) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (w_rx_zero && r_rx_bit == 3'd7) w_rx_next = S_STOP;
         S_STOP:  if (w_rx_zero) w_rx_next = S_IDLE;
         default: w_rx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_s3    <= 1'b1;
         r_rx_cnt   <= 16'd0;
         r_rx_div   <= LP_DIV_RST;
         r_rx_bit   <= 3'd0;
         r_rx_shift <= 8'd0;
      end else begin
         r_rx_s1 <= uart_rxd;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
         case (r_rx_state)
            S_IDLE:  if (w_rx_fall) begin
                        r_rx_cnt <= (r_div >> 1) - 16'd1;
                        r_rx_div <= r_div;
                     end
            S_START: if (w_rx_zero) begin
                        r_rx_cnt <= r_rx_div - 16'd1;
                        r_rx_bit <= 3'd0;
                     end else r_rx_cnt <= r_rx_cnt - 16'd1;
            S_DATA:  if (w_rx_zero) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        r_rx_cnt   <= r_rx_div - 16'd1;
                     end else r_rx_cnt <= r_rx_cnt - 16'd1;
            S_STOP:  if (!w_rx_zero) r_rx_cnt <= r_rx_cnt - 16'd1;
            default: ;
         endcase
      end
   end

   // Completion is ordered after the bus clears so a new byte always wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_byte  <= 8'd0;
         r_rx_valid <= 1'b0;
         r_rx_ovr   <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         if (w_wr_rx) r_rx_valid <= 1'b0;
         if (w_wr_stat && uart_write_data[STAT_RX_OVR])  r_rx_ovr  <= 1'b0;
         if (w_wr_stat && uart_write_data[STAT_RX_FERR]) r_rx_ferr <= 1'b0;
         if (w_rx_done && r_rx_s2) begin
            r_rx_byte  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            if (r_rx_valid) r_rx_ovr <= 1'b1;
         end
         if (w_rx_done && !r_rx_s2) r_rx_ferr <= 1'b1;
      end
   end
`else
   assign w_rx_valid = 1'b0;
   assign w_rx_ovr   = 1'b0;
   assign w_rx_ferr  = 1'b0;
   assign w_rx_byte  = 8'd0;
`endif

   always_comb begin
      w_status                = '0;
      w_status[STAT_TX_BUSY]  = (r_tx_state != S_IDLE) || !w_fifo_empty;
      w_status[STAT_TX_FULL]  = w_fifo_full;
      w_status[STAT_RX_VALID] = w_rx_valid;
      w_status[STAT_TX_OVF]   = r_tx_ovf;
      w_status[STAT_RX_OVR]   = w_rx_ovr;
      w_status[STAT_RX_FERR]  = w_rx_ferr;
      uart_read_data          = 32'd0;
      case (uart_addr[3:2])
         REG_STATUS: uart_read_data = {26'd0, w_status};
         REG_RXDATA: uart_read_data = {24'd0, w_rx_byte};
         REG_DIV:    uart_read_data = {16'd0, r_div};
         default:    uart_read_data = 32'd0;
      endcase
   end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral that answers CPU data accesses routed by the system bus to the 0x2000_0000 region. It accepts bus writes and returns read data combinationally in the same cycle, like ROM/RAM on that bus. It serialises bytes onto `uart_txd` (8N1, 4-entry TX FIFO) and optionally deserialises `uart_rxd`. Only `uart_addr[3:2]` is decoded; the bus has already qualified the region.

## Interface
- `DIV_DEFAULT`, 434 — reset value of the baud divider, in clk cycles per bit.
- `FIFO_DEPTH`, 4 — TX FIFO entries; must be a power of 2.
- `clk` in 1 — system clock. One clock; all state is in this domain.
- `rst` in 1 — asynchronous, active-high reset.
- `uart_addr` in 32 — bus address; bits [3:2] select the register.
- `uart_write_data` in 32 — bus write data.
- `uart_wen` in 1 — write strobe, one cycle per write.
- `uart_read_data` out 32 — combinational read data for the addressed register.
- `uart_txd` out 1 — serial output; idles high.
- `uart_rxd` in 1 — serial input; asynchronous to `clk`.

## Operation
- Register map, by `addr[3:2]`:
  - 0 TXDATA: a write pushes `data[7:0]` into the TX FIFO; reads return 0.
  - 1 STATUS: read only apart from the clear bits below.
    - bit0 `tx_busy`: FSM not in IDLE, or FIFO non-empty.
    - bit1 `tx_full`.
    - bit2 `rx_valid`.
    - bit3 `tx_ovf`: sticky.
    - bit4 `rx_ovr`: sticky.
    - bit5 `rx_ferr`: sticky.
    - Writing 1 to bits 3..5 clears those bits.
  - 2 RXDATA: reads return `{24'b0, rx_byte}`. Any write clears `rx_valid`.
  - 3 DIV: read/write, `[15:0]`. Writes below 2 are stored as 2.
- Reads have no side effects, because the bus carries no read strobe.
- Write to TXDATA while the FIFO is full: the byte is dropped and `tx_ovf` is set. Exception: if the TX FSM pops in the same cycle, the write is accepted and the FIFO count is unchanged.
- TX FSM states:
  - IDLE: `txd` is 1. Pops the FIFO when it is non-empty, then goes to START.
  - START: `txd` is 0.
  - DATA: 8 bits, LSB first.
  - STOP: `txd` is 1. Goes to START with the next byte if the FIFO is non-empty (no idle gap), else to IDLE.
- Every state except IDLE lasts exactly DIV cycles, counted by a 16-bit down-counter.
- The DIV value is latched at each frame start. A write to DIV mid-frame affects only later frames.
- RX FSM (present when `UART_RX_EN` is defined):
  - `uart_rxd` passes through a 2-flop synchroniser.
  - IDLE: a falling edge of the synchronised line moves to START.
  - START: waits DIV/2 cycles, then samples. Low moves to DATA; high is a glitch and returns to IDLE.
  - DATA: 8 samples, DIV cycles apart.
  - STOP: one sample, DIV cycles later.
  - Stop bit 1: load `rx_byte` and set `rx_valid`. If `rx_valid` was already 1, also set `rx_ovr`; the new byte overwrites the old one.
  - Stop bit 0: set `rx_ferr`, discard the byte, leave `rx_valid` unchanged.
- Simultaneous RXDATA clear-write and RX completion in the same cycle: the new byte wins and `rx_valid` stays 1.

## Timing
- Reset values:
  - `uart_txd` = 1.
  - FIFO empty.
  - Both FSMs in IDLE.
  - DIV = `DIV_DEFAULT`.
  - All STATUS bits 0.
  - `rx_byte` = 0.
- Reset mid-frame forces `uart_txd` high immediately (asynchronous) and abandons the frame and FIFO contents.
- `uart_read_data` follows `uart_addr` combinationally. A register written at edge N reads back its new value from cycle N+1.
- TXDATA write at edge N with the FIFO empty and the FSM idle:
  - FIFO count is 1 after edge N.
  - FSM pops at edge N+1.
  - `uart_txd` falls after edge N+1.
  - Frame is 10×DIV cycles.
  - `tx_busy` drops after the last STOP cycle.
- `tx_full` asserts after the edge at which the FIFO count reaches `FIFO_DEPTH`.
- RX latency: `rx_valid` rises 2 (synchroniser) + DIV/2 + 9×DIV cycles after the line's falling edge, ±1 cycle.

## Configuration
- `UART_RX_EN` defined: RX synchroniser, RX FSM, `rx_byte`, and STATUS bits 2/4/5 are built.
- `UART_RX_EN` undefined:
  - `uart_rxd` is ignored.
  - RXDATA and STATUS bits 2/4/5 read 0.
  - Writes to RXDATA are ignored.
  - No RX logic is synthesised.

## Structure
- Shared package `uart_pkg` holds:
  - Register offset constants: TXDATA/STATUS/RXDATA/DIV = 0..3.
  - STATUS bit index constants.
  - TX/RX state encodings: IDLE, START, DATA, STOP.
  - The DIV minimum constant (2).
- Sub-module `uart_fifo`: synchronous FIFO, `FIFO_DEPTH` × 8 bits, with push/pop/full/empty/count. It supports push and pop in the same cycle.
- TX, RX and register logic live in the top module.

## Test plan
- Reset, then read all four registers with `DIV_DEFAULT`=434:
  - STATUS = 0, RXDATA = 0, DIV = 434, TXDATA = 0.
  - `uart_txd` = 1.
- DIV=4, write 0xA5 to TXDATA:
  - `uart_txd` carries 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles.
  - `tx_busy` clears 40 cycles after the start bit begins.
- DIV=4, 6 back-to-back TXDATA writes of 0x01..0x06:
  - Bytes 0x01..0x05 are transmitted with no gap between frames.
  - 0x06 is dropped and `tx_ovf` = 1.
  - Writing 0x08 to STATUS clears `tx_ovf`.
- Write 1 to DIV:
  - DIV reads 2.
  - A DIV write during a frame leaves that frame's bit length unchanged.
- `UART_RX_EN` defined, DIV=4, drive 0x3C 8N1 on `uart_rxd`:
  - RXDATA = 0x3C and `rx_valid` = 1.
  - A second byte before the clear sets `rx_ovr`.
  - A stop bit of 0 sets `rx_ferr`.
- `rst` pulsed mid-frame:
  - `uart_txd` goes to 1 in the same cycle.
  - FIFO is empty and STATUS = 0 after release.
